// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the smoothing-MAC family.
//   state_e     : control states of the mac_inverse decoder (IDLE, BUSY, DONE)
//   COEF_NUM    : default numerator of the smoothing coefficient b
//   COEF_FRAC   : default fractional bits of b (b = COEF_NUM / 2**COEF_FRAC)
//   calc_iters  : number of shift-subtract steps the constant divider needs
// -----------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int COEF_NUM  = 13;
  localparam int COEF_FRAC = 4;

  // The dividend is |diff| (width+1 bits) scaled by 2**frac, so the divider
  // has to walk width+frac+1 bits, one per step.
  function automatic int calc_iters(input int width, input int frac);
    return width + frac + 1;
  endfunction

endpackage

// File: rtl/div_const_serial.sv
// -----------------------------------------------------------------------------
// div_const_serial
// Unsigned iterative restoring divider by a constant divisor. One quotient bit
// is produced per clock, MSB first.
//
// Parameters:
//   dw_p       dividend / quotient width (also the number of steps)
//   divisor_p  constant divisor, must be > 0
// Ports:
//   clk_i       in   clock, rising edge
//   reset_ni    in   asynchronous active-low reset, clears all registers
//   start_i     in   load dividend_i; the first step is taken on this edge
//   dividend_i  in   [dw_p-1:0] unsigned dividend
//   busy_o      out  steps still outstanding
//   done_o      out  one-cycle pulse: quotient_o holds the final quotient
//   quotient_o  out  [dw_p-1:0] truncated quotient
//
// Timing: start on edge t0 performs step 1, edges t0+1 .. t0+dw_p-1 perform
// the remaining steps, so done_o is high in the cycle after edge t0+dw_p-1.
// A consumer registering the quotient on done_o therefore lands on t0+dw_p.
// -----------------------------------------------------------------------------
module div_const_serial #(
  parameter int dw_p      = 29,
  parameter int divisor_p = 13
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            start_i,
  input  logic [dw_p-1:0] dividend_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [dw_p-1:0] quotient_o
);

  // Remainder is always < divisor, so rm_lp bits hold it; the shifted
  // partial remainder needs one more bit before the compare.
  localparam int rm_lp = (divisor_p > 1) ? $clog2(divisor_p + 1) : 1;
  localparam int sh_lp = rm_lp + 1;
  localparam int cw_lp = $clog2(dw_p + 1);

  localparam logic [sh_lp-1:0] divisor_lp = sh_lp'(divisor_p);
  localparam logic [cw_lp-1:0] last_lp    = cw_lp'(dw_p - 1);

  logic [rm_lp-1:0] rem_q, rem_src, rem_d;
  logic [sh_lp-1:0] rem_shift;
  logic [dw_p-1:0]  quo_q, quo_src, quo_d;
  logic [cw_lp-1:0] cnt_q;
  logic             bit_d;

  // quo_q doubles as the dividend shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    rem_src   = start_i ? '0 : rem_q;
    quo_src   = start_i ? dividend_i : quo_q;
    rem_shift = {rem_src, quo_src[dw_p-1]};
    rem_d     = rem_shift[rm_lp-1:0];
    bit_d     = 1'b0;
    if (rem_shift >= divisor_lp) begin
      rem_d = rm_lp'(rem_shift - divisor_lp);
      bit_d = 1'b1;
    end
    quo_d = {quo_src[dw_p-2:0], bit_d};
  end

  // cnt_q counts completed steps; it restarts at 1 on start because the
  // first step is folded into the load edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cw_lp'(1);
      busy_o <= 1'b1;
      done_o <= 1'b0;
    end else if (busy_o) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q + cw_lp'(1);
      done_o <= 1'b0;
      if (cnt_q == last_lp) begin
        busy_o <= 1'b0;
        done_o <= 1'b1;
      end
    end else begin
      done_o <= 1'b0;
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/mac_inverse.sv
// -----------------------------------------------------------------------------
// mac_inverse
// Decoder for the first-order smoothing MAC y[n] = y[n-1] + b*(x[n]-y[n-1]),
// b = coef_num_p / 2**coef_frac_p. Reconstructs
//   x[n] = y[n-1] + trunc((y[n]-y[n-1]) * 2**coef_frac_p / coef_num_p)
// with truncation toward zero and two's-complement wrap to width_p bits.
// One sample in flight; latency N = width_p+coef_frac_p+1 edges from accept to
// valid_o, back-to-back throughput one sample per N+1 cycles.
//
// Ports:
//   clk_i     in   clock, rising edge
//   reset_ni  in   asynchronous active-low reset
//   valid_i   in   data_i carries y[n]
//   data_i    in   [width_p-1:0] signed smoothed sample
//   ready_o   out  block accepts data_i this cycle
//   valid_o   out  data_o carries x[n]
//   data_o    out  [width_p-1:0] signed reconstructed sample
//   ready_i   in   downstream takes data_o this cycle
//
// Handshake: a transfer happens on every rising edge where valid & ready are
// both high on the same channel. ready_o depends combinationally on ready_i
// (DONE can hand off and accept on one edge); valid_o and data_o come straight
// from registers and hold until taken. Upstream must keep valid_i/data_i
// stable while ready_o is low; they are not looked at during BUSY.
// -----------------------------------------------------------------------------
module mac_inverse
  import mac_pkg::*;
#(
  parameter int width_p     = 24,
  parameter int coef_num_p  = COEF_NUM,
  parameter int coef_frac_p = COEF_FRAC
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  localparam int n_lp = calc_iters(width_p, coef_frac_p);

  // state_q is the single observable FSM state for checkers and debug.
  state_e state_q, state_d;

  logic [width_p-1:0] y_prev_q, base_q, data_q;
  logic               sign_q;

  logic               accept;
  logic               div_busy, div_done;
  logic [n_lp-1:0]    quotient;
  logic [width_p:0]   diff, mag;
  logic [n_lp-1:0]    dividend;
  logic [n_lp:0]      base_ext, q_ext, q_signed;
  logic [width_p-1:0] result;

  // ---------------------------------------------------------------- datapath
  // One extra bit makes the difference of two width_p samples exact.
  always_comb begin
    diff     = {data_i[width_p-1], data_i} - {y_prev_q[width_p-1], y_prev_q};
    mag      = diff[width_p] ? (~diff + 1'b1) : diff;
    dividend = {mag, {coef_frac_p{1'b0}}};
  end

  // Sign is applied after the unsigned divide so the truncation is toward
  // zero; the sum is formed wide and only the low width_p bits are kept.
  always_comb begin
    base_ext = {{(n_lp + 1 - width_p){base_q[width_p-1]}}, base_q};
    q_ext    = {1'b0, quotient};
    q_signed = sign_q ? (~q_ext + 1'b1) : q_ext;
    result   = width_p'(base_ext + q_signed);
  end

  div_const_serial #(
    .dw_p      (n_lp),
    .divisor_p (coef_num_p)
  ) u_div (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .start_i    (accept),
    .dividend_i (dividend),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  // --------------------------------------------------------------------- fsm
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // div_busy is never high in IDLE/DONE; gating on it guarantees the divider
  // is never restarted underneath an in-flight sample.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = !div_busy;
        if (valid_i && ready_o) state_d = BUSY;
      end
      BUSY: begin
        if (div_done) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i && !div_busy;
        if (ready_i) state_d = (valid_i && ready_o) ? BUSY : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept = valid_i && ready_o;

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      y_prev_q <= '0;
      base_q   <= '0;
      sign_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      if (accept) begin
        base_q   <= y_prev_q;
        y_prev_q <= data_i;
        sign_q   <= diff[width_p];
      end
      if (state_q == BUSY && div_done) begin
        data_q <= result;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_mac_inverse.sv
// -----------------------------------------------------------------------------
// tb_mac_inverse
// Directed bench for mac_inverse: driver tasks push hand-computed results and
// accept times into queues; a negedge monitor pops and compares whenever the
// DUT hands a sample downstream.
// -----------------------------------------------------------------------------
module tb_mac_inverse;

  localparam int W = 24;
  localparam int N = 29;

  // ------------------------------------------------------- clock and reset
  logic         clk      = 1'b0;
  logic         reset_ni = 1'b0;
  logic         valid_i  = 1'b0;
  logic         ready_i  = 1'b1;
  logic [W-1:0] data_i   = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mac_inverse #(
    .width_p     (W),
    .coef_num_p  (13),
    .coef_frac_p (4)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .ready_i  (ready_i)
  );

  // ------------------------------------------------------------ scoreboard
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  bit           fresh = 1'b1;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the first cycle a result is shown, data on handoff.
  always @(negedge clk) begin
    if (reset_ni && valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d with nothing expected", $signed(data_o));
      end else begin
        if (fresh) begin
          check("latency", cyc - acc_q[0], N);
          fresh = 1'b0;
        end
        if (ready_i) begin
          check("data_o", int'($signed(data_o)), int'($signed(exp_q.pop_front())));
          void'(acc_q.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic send(input int y, input int exp, input bit track);
    int waited = 0;
    valid_i = 1'b1;
    data_i  = W'(y);
    @(negedge clk);
    while (!ready_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_o=%0d after %0d cycles, expected 1", ready_o, waited);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (track) begin
      exp_q.push_back(W'(exp));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Reset is dropped between edges and checked before any edge arrives.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2;
    reset_ni = 1'b0;
    valid_i  = 1'b0;
    exp_q.delete();
    acc_q.delete();
    fresh = 1'b1;
    #1;
    check({tag, "_valid_o"}, int'(valid_o), 0);
    check({tag, "_ready_o"}, int'(ready_o), 1);
    check({tag, "_data_o"}, int'($signed(data_o)), 0);
    repeat (2) @(posedge clk);
    #2;
    reset_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    // 1: basic stream, back-to-back, latency checked by the monitor
    apply_reset("rst1");
    ready_i = 1'b1;
    send(0, 0, 1);
    send(13, 16, 1);
    send(13, 13, 1);
    send(0, -3, 1);
    drain();

    // 2: truncation toward zero
    apply_reset("rst2");
    send(1, 1, 1);
    send(0, 0, 1);
    drain();

    // 3: wrap of the full-width sum
    apply_reset("rst3");
    send(8388607, -6452777, 1);
    drain();

    // 4: backpressure in DONE with a pending new sample
    apply_reset("rst4");
    ready_i = 1'b0;
    send(26, 32, 1);
    begin
      int waited = 0;
      while (!valid_o && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check("bp_valid_seen", int'(valid_o), 1);
    end
    valid_i = 1'b1;
    data_i  = W'(39);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_o", int'(valid_o), 1);
      check("bp_data_o", int'($signed(data_o)), 32);
      check("bp_ready_o", int'(ready_o), 0);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    send(39, 42, 1);
    @(negedge clk);
    check("bp_busy_ready_o", int'(ready_o), 0);
    check("bp_busy_valid_o", int'(valid_o), 0);
    drain();

    // 5: reset in the middle of BUSY clears y_prev
    apply_reset("rst5a");
    send(100, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_busy_ready_o", int'(ready_o), 0);
    apply_reset("rst5b");
    send(13, 16, 1);
    drain();

    // 6: inputs toggled during BUSY are ignored
    apply_reset("rst6");
    send(13, 16, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      valid_i = (i % 2 == 0);
      data_i  = W'(500 + i * 37);
      @(negedge clk);
      check("busy_ready_o", int'(ready_o), 0);
    end
    valid_i = 1'b0;
    drain();
    send(26, 29, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
